seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to begin one multiplication; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-006 Port: multiplicand  input  WIDTH  operand A; sampled with start.
REQ-007 Port: multiplier  input  WIDTH  operand B; sampled with start.
REQ-008 Port: busy  output  1  high in CALC and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse when product is updated.
REQ-010 Port: product  output  2*WIDTH  registered result of the last completed operation.

Function
REQ-011 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-012 IDLE with start=1: latch operands, is_signed and result sign; clear accumulator and bit counter; go to CALC. IDLE with start=0: stay in IDLE.
REQ-013 Operand latch: if is_signed=1, store magnitudes |A|, |B| as WIDTH-bit unsigned values, with result sign = A[MSB] xor B[MSB]; if is_signed=0, store A and B unchanged, with sign = 0.
REQ-014 Most-negative operand (e.g. -8 for WIDTH=4): the magnitude 2^(WIDTH-1) SHALL be stored correctly as unsigned.
REQ-015 CALC, one multiplier bit per cycle, LSB first: if the current bit is 1, add the multiplicand shifted left by counter to the 2*WIDTH accumulator; increment counter.
REQ-016 CALC SHALL last exactly WIDTH cycles; there is no early termination on zero operands.
REQ-017 Transition CALC->DONE occurs on the cycle the counter reaches WIDTH-1.
REQ-018 DONE: product <= sign ? (two's-complement negate of accumulator) : accumulator; done=1 for that single cycle; next state IDLE.
REQ-019 Fixed latency: start sampled at edge t gives done=1 and the new product valid in the cycle after edge t+WIDTH+1.
REQ-020 start while busy=1 SHALL be ignored; latched operands SHALL not change mid-operation.
REQ-021 product SHALL hold its value between completions; it SHALL not change during CALC.
REQ-022 Arithmetic: the accumulator is 2*WIDTH bits, so no overflow is possible; the negate wraps modulo 2^(2*WIDTH).
REQ-023 Back-to-back: start held high SHALL begin a new operation in the IDLE cycle that follows DONE.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, product=0, done=0, busy=0, accumulator=0, counter=0.
REQ-025 Reset during CALC or DONE SHALL abort the operation; no done pulse is produced and product reads 0.
REQ-026 Reset SHALL take priority over start in the same cycle.

Structure
REQ-027 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) SHALL live in the shared calculator package calc_pkg, for reuse by the calculator top-level FSM.
REQ-028 The block SHALL be a single module; a sub-module is not warranted. Counter width is $clog2(WIDTH), computed locally.

Verification (WIDTH=4 unless stated)
REQ-029 Unsigned: is_signed=0, A=13, B=11 -> done after 6 cycles; product=8'h8F (143).
REQ-030 Signed: is_signed=1, A=4'hD (-3), B=5 -> product=8'hF1 (-15). Also A=-8, B=-8 -> product=8'h40 (64).
REQ-031 Extremes: A=15, B=15 unsigned -> 8'hE1; A=0, B=9 -> 8'h00, with full latency preserved.
REQ-032 Handshake: pulse start with A=3, B=4; re-assert start with A=7, B=7 in the 2nd CALC cycle -> product=12, exactly one done pulse; the second request is ignored.
REQ-033 Reset: assert rst_n=0 in the 3rd CALC cycle of 9x9 -> next cycle IDLE, product=0, busy=0, no done pulse; a following 2x3 -> 6.
REQ-034 Parameter sweep: WIDTH=8, signed, A=-128, B=127 -> product=16'hC080 after 10 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator package: FSM state encodings and widths used by the
// sequential arithmetic units and the calculator top-level FSM.
package calc_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] CALC = 2'd1;
  localparam logic [STATE_W-1:0] DONE = 2'd2;

endpackage : calc_pkg

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle (LSB first).
// Signed operands are converted to magnitudes at start and the product sign is
// applied when the result is written back.
//
// Ports:
//   clk          - clock, all state changes on rising edge
//   rst_n        - synchronous active-low reset
//   start        - begin a multiplication (sampled only in IDLE)
//   is_signed    - 1 = two's-complement operands, 0 = unsigned
//   multiplicand - operand A
//   multiplier   - operand B
//   busy         - high while in CALC or DONE
//   done         - one-cycle pulse when product is updated
//   product      - result of the last completed operation
module seq_multiplier
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             sign;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic             last_c;
  logic [PW-1:0]    addend_c;

  // Magnitudes; -(2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  always_comb begin
    mag_a_c = multiplicand;
    mag_b_c = multiplier;
    if (is_signed && multiplicand[WIDTH-1]) mag_a_c = WIDTH'(-multiplicand);
    if (is_signed && multiplier[WIDTH-1])   mag_b_c = WIDTH'(-multiplier);
  end

  // Partial product for the current multiplier bit.
  always_comb begin
    last_c   = (cnt == CW'(WIDTH - 1));
    addend_c = '0;
    if (mplier[cnt]) addend_c = PW'(mcand) << cnt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      sign    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a_c;
            mplier <= mag_b_c;
            sign   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc <= acc + addend_c;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          product <= sign ? PW'(-acc) : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: WIDTH=4 instance driven through a
// scoreboard queue, plus a WIDTH=8 instance for a single signed case.
module tb_seq_multiplier;

  localparam int unsigned W  = 4;
  localparam int unsigned W8 = 8;

  logic clk;
  logic rst_n;

  logic           start;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic            start8;
  logic            is_signed8;
  logic [W8-1:0]   multiplicand8;
  logic [W8-1:0]   multiplier8;
  logic            busy8;
  logic            done8;
  logic [2*W8-1:0] product8;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  seq_multiplier #(.WIDTH(W8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start8),
    .is_signed    (is_signed8),
    .multiplicand (multiplicand8),
    .multiplier   (multiplier8),
    .busy         (busy8),
    .done         (done8),
    .product      (product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    issued;
  } exp_t;

  exp_t           sb[$];
  int unsigned    n_checks = 0;
  int unsigned    n_fail   = 0;
  int unsigned    n_done   = 0;
  logic [2*W-1:0] held_exp = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    int x;
    int y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    return (2*W)'(x * y);
  endfunction

  // Output monitor: pops the scoreboard on each done pulse, checks product
  // stability while busy.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("product", 64'(product), 64'(e.prod));
        check_eq("latency", 64'(cyc - e.issued), 64'(W + 2));
        check_eq("busy_low_at_done", 64'(busy), 64'(0));
        held_exp = e.prod;
      end
    end else if (busy) begin
      check_eq("product_hold", 64'(product), 64'(held_exp));
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0 || busy) begin
      check_eq("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    start        = 1'b1;
    e.prod       = model(a, b, s);
    e.issued     = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int unsigned n0;
    int unsigned nd;
    int k;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    rst_n = 1'b0;
    start = 1'b0; is_signed = 1'b0; multiplicand = '0; multiplier = '0;
    start8 = 1'b0; is_signed8 = 1'b0; multiplicand8 = '0; multiplier8 = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_product", 64'(product), 64'(0));
    check_eq("reset_busy",    64'(busy),    64'(0));
    check_eq("reset_done",    64'(done),    64'(0));
    check_eq("reset_product8", 64'(product8), 64'(0));
    rst_n = 1'b1;

    // Directed cases.
    issue(4'd13, 4'd11, 1'b0); drain();
    check_eq("unsigned_13x11", 64'(product), 64'(8'h8F));
    issue(4'hD, 4'd5, 1'b1);   drain();
    check_eq("signed_m3x5", 64'(product), 64'(8'hF1));
    issue(4'h8, 4'h8, 1'b1);   drain();
    check_eq("signed_m8xm8", 64'(product), 64'(8'h40));
    issue(4'hF, 4'hF, 1'b0);   drain();
    check_eq("unsigned_15x15", 64'(product), 64'(8'hE1));
    issue(4'd0, 4'd9, 1'b0);   drain();
    check_eq("zero_x9", 64'(product), 64'(8'h00));
    issue(4'h8, 4'd7, 1'b1);   drain();
    issue(4'h8, 4'h8, 1'b0);   drain();

    // Start re-asserted mid-operation must be ignored.
    n0 = n_done;
    issue(4'd3, 4'd4, 1'b0);
    @(negedge clk);
    multiplicand = 4'd7; multiplier = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);
    check_eq("ignored_start_done_count", 64'(n_done - n0), 64'(1));
    check_eq("ignored_start_product", 64'(product), 64'(12));

    // Back-to-back: start held high through DONE starts the next op at once.
    @(negedge clk);
    begin
      exp_t e1;
      exp_t e2;
      multiplicand = 4'd5; multiplier = 4'd6; is_signed = 1'b0; start = 1'b1;
      e1.prod = model(4'd5, 4'd6, 1'b0); e1.issued = cyc;
      e2.prod = model(4'd7, 4'd3, 1'b0); e2.issued = cyc + W + 2;
      sb.push_back(e1);
      sb.push_back(e2);
      @(negedge clk);
      multiplicand = 4'd7; multiplier = 4'd3;
      k = 0;
      while (cyc < e2.issued + 1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      start = 1'b0;
    end
    drain();
    check_eq("back_to_back_product", 64'(product), 64'(8'd21));

    // Reset in the 3rd CALC cycle aborts the operation.
    n0 = n_done;
    @(negedge clk);
    multiplicand = 4'd9; multiplier = 4'd9; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy",    64'(busy),    64'(0));
    check_eq("abort_product", 64'(product), 64'(0));
    check_eq("abort_done",    64'(done),    64'(0));
    held_exp = '0;
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check_eq("abort_no_done", 64'(n_done - n0), 64'(0));
    check_eq("abort_product_held", 64'(product), 64'(0));
    issue(4'd2, 4'd3, 1'b0); drain();
    check_eq("after_abort_2x3", 64'(product), 64'(6));

    // Reset takes priority over start.
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; multiplicand = 4'd3; multiplier = 4'd3;
    @(negedge clk);
    check_eq("rst_over_start_busy", 64'(busy), 64'(0));
    check_eq("rst_over_start_product", 64'(product), 64'(0));
    held_exp = '0;
    start = 1'b0; rst_n = 1'b1;

    // Random cases.
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs);
      drain();
    end

    // WIDTH=8 signed case.
    @(negedge clk);
    n0 = cyc;
    multiplicand8 = 8'h80; multiplier8 = 8'd127; is_signed8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    nd = cyc;
    check_eq("w8_done_seen", 64'(done8), 64'(1));
    check_eq("w8_product", 64'(product8), 64'(16'hC080));
    check_eq("w8_latency", 64'(nd - n0), 64'(W8 + 2));

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_multiplier
